// File: rtl/conbus_pkg.sv
// Shared widths, Wishbone cycle-type codes and helpers for the conbus_rr interconnect.
package conbus_pkg;

  localparam int ADR_W = 32;
  localparam int DAT_W = 32;
  localparam int CTI_W = 3;
  localparam int SEL_W = 4;

  localparam logic [CTI_W-1:0] CLASSIC = 3'b000;
  localparam logic [CTI_W-1:0] CONST   = 3'b001;
  localparam logic [CTI_W-1:0] INCR    = 3'b010;
  localparam logic [CTI_W-1:0] END     = 3'b111;

  typedef enum logic {
    ARB_IDLE,
    ARB_OWNED
  } arb_state_e;

  // Number of bits needed to hold values 0..value-1; clog2(1) is 0.
  function automatic int clog2(input int value);
    int bits = 0;
    int rem = value - 1;
    while (rem > 0) begin
      bits++;
      rem = rem >> 1;
    end
    return bits;
  endfunction

endpackage

// File: rtl/conbus_rr_arb.sv
// Round-robin bus arbiter: a grant is held for as long as its owner keeps cyc asserted,
// and the search for the next owner starts just above the previous one.
module conbus_rr_arb
  import conbus_pkg::*;
#(
  parameter int N_M = 6
) (
  input  logic           sys_clk,
  input  logic           sys_rst,
  input  logic [N_M-1:0] req,
  output logic [N_M-1:0] gnt
);

  localparam int IDX_W = clog2(N_M);

  arb_state_e     state_q, state_d;
  logic [N_M-1:0] gnt_q, gnt_d;
  logic [IDX_W-1:0] last_q, last_d, owner_idx;
  logic [N_M-1:0] mask, req_hi, pick;

  // NOTE: state registers use non-blocking assignments; combinational blocks use blocking ones.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q <= ARB_IDLE;
      gnt_q   <= '0;
      last_q  <= IDX_W'(N_M - 1);
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      last_q  <= last_d;
    end
  end

  // Requests above the last owner win first; the plain lowest request covers the wrap.
  always_comb begin
    // NOTE: every signal written here gets a default first, so no latch can be inferred.
    mask      = '0;
    owner_idx = '0;
    for (int i = 0; i < N_M; i++) begin
      mask[i] = (IDX_W'(i) > last_q);
      if (gnt_q[i]) owner_idx = IDX_W'(i);
    end
    req_hi = req & mask;
    pick   = (|req_hi) ? (req_hi & (-req_hi)) : (req & (-req));
  end

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    last_d  = last_q;
    case (state_q)
      ARB_IDLE: begin
        if (|req) begin
          gnt_d   = pick;
          state_d = ARB_OWNED;
        end
      end
      ARB_OWNED: begin
        if (!(|(req & gnt_q))) begin
          gnt_d   = '0;
          last_d  = owner_idx;
          state_d = ARB_IDLE;
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  always_comb begin
    gnt = gnt_q;
  end

endmodule

// File: rtl/conbus_rr.sv
// Shared-bus Wishbone interconnect: N_M masters, N_S slaves, round-robin arbitration,
// address decode, and bus errors for unmapped addresses and unresponsive slaves.
module conbus_rr
  import conbus_pkg::*;
#(
  parameter int                      N_M        = 6,
  parameter int                      N_S        = 8,
  parameter int                      S_ADDR_W   = 4,
  parameter logic [N_S*S_ADDR_W-1:0] S_ADDR_MAP = 32'h7654_3210,
  parameter int                      TMO_CYC    = 255
) (
  input  logic                 sys_clk,
  input  logic                 sys_rst,
  input  logic [N_M*DAT_W-1:0] m_dat_i,
  input  logic [N_M*ADR_W-1:0] m_adr_i,
  input  logic [N_M*CTI_W-1:0] m_cti_i,
  input  logic [N_M*SEL_W-1:0] m_sel_i,
  input  logic [N_M-1:0]       m_we_i,
  input  logic [N_M-1:0]       m_cyc_i,
  input  logic [N_M-1:0]       m_stb_i,
  output logic [DAT_W-1:0]     m_dat_o,
  output logic [N_M-1:0]       m_ack_o,
  output logic [N_M-1:0]       m_err_o,
  input  logic [N_S*DAT_W-1:0] s_dat_i,
  input  logic [N_S-1:0]       s_ack_i,
  input  logic [N_S-1:0]       s_err_i,
  output logic [DAT_W-1:0]     s_dat_o,
  output logic [ADR_W-1:0]     s_adr_o,
  output logic [CTI_W-1:0]     s_cti_o,
  output logic [SEL_W-1:0]     s_sel_o,
  output logic                 s_we_o,
  output logic [N_S-1:0]       s_cyc_o,
  output logic [N_S-1:0]       s_stb_o,
  output logic [N_M-1:0]       gnt_o
);

  localparam int               CNT_W   = clog2(TMO_CYC + 1);
  localparam logic [CNT_W-1:0] TMO_MAX = CNT_W'(TMO_CYC);

  logic [N_M-1:0]   gnt;
  logic             any_gnt;
  logic [DAT_W-1:0] own_dat;
  logic [ADR_W-1:0] own_adr;
  logic [CTI_W-1:0] own_cti;
  logic [SEL_W-1:0] own_bsel;
  logic             own_we, own_cyc, own_stb;
  logic [N_S-1:0]   slv_hit, slv_sel;
  logic             ack_any, err_any;
  logic             dec_err_q, dec_err_d;
  logic             tmo_err_q, tmo_err_d, tmo_run;
  logic [CNT_W-1:0] tmo_cnt, tmo_cnt_d;

  conbus_rr_arb #(
    .N_M(N_M)
  ) u_arb (
    .sys_clk(sys_clk),
    .sys_rst(sys_rst),
    .req    (m_cyc_i),
    .gnt    (gnt)
  );

  assign any_gnt = |gnt;
  assign gnt_o   = gnt;

  // AND-OR mux of the granted master; an all-zero grant yields an all-zero bus.
  always_comb begin
    own_dat  = '0;
    own_adr  = '0;
    own_cti  = '0;
    own_bsel = '0;
    own_we   = 1'b0;
    own_cyc  = 1'b0;
    own_stb  = 1'b0;
    for (int i = 0; i < N_M; i++) begin
      own_dat  |= m_dat_i[i*DAT_W +: DAT_W] & {DAT_W{gnt[i]}};
      own_adr  |= m_adr_i[i*ADR_W +: ADR_W] & {ADR_W{gnt[i]}};
      own_cti  |= m_cti_i[i*CTI_W +: CTI_W] & {CTI_W{gnt[i]}};
      own_bsel |= m_sel_i[i*SEL_W +: SEL_W] & {SEL_W{gnt[i]}};
      own_we   |= m_we_i[i] & gnt[i];
      own_cyc  |= m_cyc_i[i] & gnt[i];
      own_stb  |= m_stb_i[i] & gnt[i];
    end
  end

  assign s_dat_o = own_dat;
  assign s_adr_o = own_adr;
  assign s_cti_o = own_cti;
  assign s_sel_o = own_bsel;
  assign s_we_o  = own_we;

  always_comb begin
    slv_hit = '0;
    for (int j = 0; j < N_S; j++) begin
      slv_hit[j] = (own_adr[ADR_W-1 -: S_ADDR_W] == S_ADDR_MAP[j*S_ADDR_W +: S_ADDR_W]);
    end
  end

  // Duplicate map entries resolve to the lowest index; nothing is selected without a grant.
  assign slv_sel = (slv_hit & (-slv_hit)) & {N_S{any_gnt}};
  assign s_cyc_o = slv_sel & {N_S{own_cyc}};
  assign s_stb_o = slv_sel & {N_S{own_cyc & own_stb}};

  always_comb begin
    m_dat_o = '0;
    for (int j = 0; j < N_S; j++) begin
      m_dat_o |= s_dat_i[j*DAT_W +: DAT_W] & {DAT_W{slv_sel[j]}};
    end
  end

  assign ack_any = |(s_ack_i & slv_sel);
  assign err_any = ((|(s_err_i & slv_sel)) | dec_err_q | tmo_err_q) & ~ack_any;
  assign m_ack_o = gnt & {N_M{ack_any}};
  assign m_err_o = gnt & {N_M{err_any}};

  // Skipping a cycle after each decode error gives a held strobe one err every two cycles.
  assign dec_err_d = own_cyc & own_stb & ~(|slv_hit) & ~dec_err_q;

  // A grant change always passes through an ungranted cycle, which clears the counter.
  assign tmo_run = own_cyc & own_stb & (|slv_sel) & ~ack_any & ~err_any;

  always_comb begin
    tmo_cnt_d = '0;
    tmo_err_d = 1'b0;
    if (tmo_run) begin
      if (tmo_cnt == TMO_MAX) tmo_err_d = 1'b1;
      else                    tmo_cnt_d = tmo_cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      dec_err_q <= 1'b0;
      tmo_err_q <= 1'b0;
      tmo_cnt   <= '0;
    end else begin
      dec_err_q <= dec_err_d;
      tmo_err_q <= tmo_err_d;
      tmo_cnt   <= tmo_cnt_d;
    end
  end

endmodule
